// File: rtl/bp_me_nonsynth_pkg.sv
// Shared statistics record layout and reset constants for the LCE latency monitor.
// The record is width-parameterised, so it is declared through macros inside each user.
`ifndef BP_ME_NONSYNTH_PKG_SV
`define BP_ME_NONSYNTH_PKG_SV

`define BP_LCE_LAT_STAT_WIDTH(lat_w, sum_w) (2*(lat_w) + 2*(sum_w))

`define DECLARE_BP_LCE_LAT_STAT_S(lat_w, sum_w) \
  typedef struct packed {                       \
    logic [(sum_w)-1:0] count;                  \
    logic [(lat_w)-1:0] min;                    \
    logic [(lat_w)-1:0] max;                    \
    logic [(sum_w)-1:0] sum;                    \
  } bp_lce_lat_stat_s

package bp_me_nonsynth_pkg;

  // min starts saturated so the first sample always replaces it
  localparam logic stat_min_rst_bit_lp = 1'b1;
  localparam logic stat_max_rst_bit_lp = 1'b0;
  localparam logic stat_acc_rst_bit_lp = 1'b0;

endpackage

`endif

// File: rtl/bp_me_nonsynth_lce_lat_chan.sv
// One monitored LCE: stamp FIFO of outstanding requests, latency subtract,
// running statistics and sticky protocol/timeout flags.
module bp_me_nonsynth_lce_lat_chan
  import bp_me_nonsynth_pkg::*;
#(
  parameter int max_out_p   = 4,
  parameter int lat_width_p = 16,
  parameter int sum_width_p = 32,
  parameter int timeout_p   = 1000,
  localparam int stat_width_lp = `BP_LCE_LAT_STAT_WIDTH(lat_width_p, sum_width_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic [lat_width_p-1:0]   stamp_i,
  input  logic                     req_fire_i,
  input  logic                     complete_i,
  output logic                     lat_v_o,
  output logic [lat_width_p-1:0]   lat_o,
  output logic [stat_width_lp-1:0] stat_o,
  output logic                     timeout_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  `DECLARE_BP_LCE_LAT_STAT_S(lat_width_p, sum_width_p);

  localparam int ptr_w_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;
  localparam int cnt_w_lp = $clog2(max_out_p + 1);
  localparam logic [ptr_w_lp-1:0]    last_ptr_lp = ptr_w_lp'(max_out_p - 1);
  localparam logic [cnt_w_lp-1:0]    full_cnt_lp = cnt_w_lp'(max_out_p);
  localparam logic [lat_width_p-1:0] timeout_lp  = lat_width_p'(timeout_p);
  localparam bp_lce_lat_stat_s stat_rst_lp = '{
    count: {sum_width_p{stat_acc_rst_bit_lp}},
    min:   {lat_width_p{stat_min_rst_bit_lp}},
    max:   {lat_width_p{stat_max_rst_bit_lp}},
    sum:   {sum_width_p{stat_acc_rst_bit_lp}}
  };

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [sum_width_p-1:0] sat_inc(input logic [sum_width_p-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  function automatic logic [sum_width_p-1:0] sat_add(input logic [sum_width_p-1:0] a,
                                                     input logic [lat_width_p-1:0] b);
    logic [sum_width_p:0] s;
    s = {1'b0, a} + (sum_width_p+1)'(b);
    return s[sum_width_p] ? '1 : s[sum_width_p-1:0];
  endfunction

  logic [lat_width_p-1:0] mem_r [max_out_p];
  logic [ptr_w_lp-1:0]    rd_ptr_r, wr_ptr_r;
  logic [cnt_w_lp-1:0]    cnt_r;
  logic                   empty, full, pop_v, push_v, timeout_now;
  logic [lat_width_p-1:0] head_stamp, elapsed_p0;
  logic                   vld_p1;
  logic [lat_width_p-1:0] lat_p1;
  bp_lce_lat_stat_s       stat_r, stat_upd;
  logic                   timeout_r, overflow_r, underflow_r;

  // Stage p0: FIFO occupancy and head age; a pop frees a slot for a same-cycle push
  assign empty       = (cnt_r == '0);
  assign full        = (cnt_r == full_cnt_lp);
  assign pop_v       = complete_i & ~empty;
  assign push_v      = req_fire_i & (~full | pop_v);
  assign head_stamp  = mem_r[rd_ptr_r];
  assign elapsed_p0  = stamp_i - head_stamp;
  assign timeout_now = ~empty & (elapsed_p0 >= timeout_lp);

  always_ff @(posedge clk_i) begin
    if (push_v) mem_r[wr_ptr_r] <= stamp_i;
  end

  // Stage p1: registered sample folds into the statistics
  always_comb begin
    stat_upd       = stat_r;
    stat_upd.count = sat_inc(stat_r.count);
    stat_upd.min   = (lat_p1 < stat_r.min) ? lat_p1 : stat_r.min;
    stat_upd.max   = (lat_p1 > stat_r.max) ? lat_p1 : stat_r.max;
    stat_upd.sum   = sat_add(stat_r.sum, lat_p1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      cnt_r       <= '0;
      vld_p1      <= 1'b0;
      lat_p1      <= '0;
      stat_r      <= stat_rst_lp;
      timeout_r   <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (pop_v)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (push_v) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (push_v & ~pop_v)      cnt_r <= cnt_r + 1'b1;
      else if (pop_v & ~push_v) cnt_r <= cnt_r - 1'b1;
      vld_p1 <= pop_v;
      if (pop_v) lat_p1 <= elapsed_p0;
      if (clear_i)     stat_r <= stat_rst_lp;
      else if (vld_p1) stat_r <= stat_upd;
      if (clear_i) begin
        timeout_r   <= 1'b0;
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end else begin
        timeout_r   <= timeout_r | timeout_now;
        overflow_r  <= overflow_r | (req_fire_i & full & ~pop_v);
        underflow_r <= underflow_r | (complete_i & empty);
      end
    end
  end

  assign lat_v_o     = vld_p1;
  assign lat_o       = lat_p1;
  assign stat_o      = stat_r;
  // live term lets the flag show in the very cycle the threshold is reached
  assign timeout_o   = timeout_r | timeout_now;
  assign overflow_o  = overflow_r;
  assign underflow_o = underflow_r;

endmodule

// File: rtl/bp_me_nonsynth_lce_latency_monitor.sv
// Multi-LCE request-to-completion latency monitor: shared free-running stamp,
// one channel per LCE, and a combinational statistics read mux.
module bp_me_nonsynth_lce_latency_monitor
  import bp_me_nonsynth_pkg::*;
#(
  parameter int num_lce_p   = 2,
  parameter int max_out_p   = 4,
  parameter int lat_width_p = 16,
  parameter int sum_width_p = 32,
  parameter int timeout_p   = 1000,
  localparam int sel_w_lp      = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int stat_width_lp = `BP_LCE_LAT_STAT_WIDTH(lat_width_p, sum_width_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             clear_i,
  input  logic [num_lce_p-1:0]             req_fire_i,
  input  logic [num_lce_p-1:0]             complete_i,
  output logic [num_lce_p-1:0]             lat_v_o,
  output logic [num_lce_p*lat_width_p-1:0] lat_o,
  input  logic [sel_w_lp-1:0]              stat_sel_i,
  output logic [stat_width_lp-1:0]         stat_o,
  output logic [num_lce_p-1:0]             timeout_o,
  output logic [num_lce_p-1:0]             overflow_o,
  output logic [num_lce_p-1:0]             underflow_o
);

  logic [lat_width_p-1:0]   stamp_r;
  logic [stat_width_lp-1:0] stat_arr [2**sel_w_lp];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) stamp_r <= '0;
    else            stamp_r <= stamp_r + 1'b1;
  end

  for (genvar i = 0; i < num_lce_p; i++) begin : chan
    bp_me_nonsynth_lce_lat_chan #(
      .max_out_p   (max_out_p),
      .lat_width_p (lat_width_p),
      .sum_width_p (sum_width_p),
      .timeout_p   (timeout_p)
    ) u_chan (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .clear_i     (clear_i),
      .stamp_i     (stamp_r),
      .req_fire_i  (req_fire_i[i]),
      .complete_i  (complete_i[i]),
      .lat_v_o     (lat_v_o[i]),
      .lat_o       (lat_o[i*lat_width_p +: lat_width_p]),
      .stat_o      (stat_arr[i]),
      .timeout_o   (timeout_o[i]),
      .overflow_o  (overflow_o[i]),
      .underflow_o (underflow_o[i])
    );
  end

  // unused select codes read as an all-zero record
  for (genvar j = num_lce_p; j < 2**sel_w_lp; j++) begin : pad
    assign stat_arr[j] = '0;
  end

  assign stat_o = stat_arr[stat_sel_i];

endmodule

// File: tb/tb_bp_me_nonsynth_lce_latency_monitor.sv
// Directed bench: cycle-indexed vector table on a 3-LCE monitor plus an 8-bit
// stamp instance for wrap-around, followed by a mid-flight reset sequence.
module tb_bp_me_nonsynth_lce_latency_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr;
  logic [2:0]  req, cpl;
  logic [2:0]  lat_v_o;
  logic [47:0] lat_o;
  logic [1:0]  stat_sel;
  logic [95:0] stat_o;
  logic [2:0]  timeout_o, overflow_o, underflow_o;

  logic        clr8 = 1'b0;
  logic        sel8 = 1'b0;
  logic [1:0]  req8, cpl8;
  logic [1:0]  lat_v8;
  logic [15:0] lat8;
  logic [47:0] stat8;
  logic [1:0]  tmo8, ovf8, unf8;

  always #5 clk = ~clk;

  bp_me_nonsynth_lce_latency_monitor #(
    .num_lce_p(3), .max_out_p(4), .lat_width_p(16), .sum_width_p(32), .timeout_p(100)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clr),
    .req_fire_i(req), .complete_i(cpl),
    .lat_v_o(lat_v_o), .lat_o(lat_o),
    .stat_sel_i(stat_sel), .stat_o(stat_o),
    .timeout_o(timeout_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  bp_me_nonsynth_lce_latency_monitor #(
    .num_lce_p(2), .max_out_p(4), .lat_width_p(8), .sum_width_p(16), .timeout_p(100)
  ) dut8 (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clr8),
    .req_fire_i(req8), .complete_i(cpl8),
    .lat_v_o(lat_v8), .lat_o(lat8),
    .stat_sel_i(sel8), .stat_o(stat8),
    .timeout_o(tmo8), .overflow_o(ovf8), .underflow_o(unf8)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  req, cpl;
    logic        clr;
    logic [1:0]  sel;
    logic [2:0]  exp_v;
    logic [15:0] lat0, lat1;
    logic [2:0]  tmo, ovf, unf;
    logic        chk_stat;
    logic [31:0] s_cnt;
    logic [15:0] s_min, s_max;
    logic [31:0] s_sum;
    logic        req8, cpl8, exp_v8;
    logic [7:0]  lat8;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic void v(int c, logic [2:0] rq, logic [2:0] cp, logic cl,
                            logic [2:0] ev, logic [15:0] l0, logic [15:0] l1,
                            logic [2:0] tm, logic [2:0] ov, logic [2:0] un);
    vec_t r;
    r = '{default: '0};
    r.cyc = c; r.req = rq; r.cpl = cp; r.clr = cl;
    r.exp_v = ev; r.lat0 = l0; r.lat1 = l1;
    r.tmo = tm; r.ovf = ov; r.unf = un;
    vecs.push_back(r);
  endfunction

  function automatic void s(int c, logic [1:0] sl, logic [31:0] cn, logic [15:0] mn,
                            logic [15:0] mx, logic [31:0] sm,
                            logic [2:0] tm, logic [2:0] ov, logic [2:0] un);
    vec_t r;
    r = '{default: '0};
    r.cyc = c; r.sel = sl; r.chk_stat = 1'b1;
    r.s_cnt = cn; r.s_min = mn; r.s_max = mx; r.s_sum = sm;
    r.tmo = tm; r.ovf = ov; r.unf = un;
    vecs.push_back(r);
  endfunction

  function automatic void w(int c, logic rq, logic cp, logic ev, logic [7:0] l);
    vec_t r;
    r = '{default: '0};
    r.cyc = c; r.req8 = rq; r.cpl8 = cp; r.exp_v8 = ev; r.lat8 = l;
    r.tmo = 3'b100;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_stat(input string tag, input logic [31:0] cn, input logic [15:0] mn,
                          input logic [15:0] mx, input logic [31:0] sm);
    chk({tag, "_count"}, stat_o[95:64], cn);
    chk({tag, "_min"},   stat_o[63:48], mn);
    chk({tag, "_max"},   stat_o[47:32], mx);
    chk({tag, "_sum"},   stat_o[31:0],  sm);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    reset_n = 1'b0; clr = 1'b0; req = '0; cpl = '0; stat_sel = '0;
    req8 = '0; cpl8 = '0;

    // LCE2 request left outstanding to hit the timeout at stamp 100
    v(0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 5; c <= 9; c++) v(c, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
    v(10, 3'b001, 0, 0, 0, 0, 0, 0, 3'b010, 0);
    v(17, 0, 3'b001, 0, 0, 0, 0, 0, 3'b010, 0);
    v(18, 0, 0, 0, 3'b001, 16'd7, 0, 0, 3'b010, 0);
    s(19, 2'd0, 32'd1, 16'd7, 16'd7, 32'd7, 0, 3'b010, 0);
    v(20, 0, 3'b010, 0, 0, 0, 0, 0, 3'b010, 0);
    for (int c = 21; c <= 23; c++) v(c, 0, 3'b010, 0, 3'b010, 0, 16'd15, 0, 3'b010, 0);
    v(24, 0, 0, 0, 3'b010, 0, 16'd15, 0, 3'b010, 0);
    s(25, 2'd1, 32'd4, 16'd15, 16'd15, 32'd60, 0, 3'b010, 0);
    v(30, 0, 3'b001, 0, 0, 0, 0, 0, 3'b010, 0);
    v(31, 0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b001);
    v(32, 0, 0, 1, 0, 0, 0, 0, 3'b010, 3'b001);
    s(33, 2'd0, 32'd0, 16'hffff, 16'd0, 32'd0, 0, 0, 0);
    v(34, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
    v(40, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0);
    v(43, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0);
    v(44, 0, 0, 0, 3'b011, 16'd3, 16'd9, 0, 0, 0);
    s(45, 2'd0, 32'd1, 16'd3, 16'd3, 32'd3, 0, 0, 0);
    s(46, 2'd1, 32'd1, 16'd9, 16'd9, 32'd9, 0, 0, 0);
    v(50, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0);
    v(55, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0);
    v(56, 0, 0, 0, 3'b001, 16'd5, 0, 0, 0, 0);
    v(60, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0);
    v(61, 0, 0, 0, 3'b001, 16'd5, 0, 0, 0, 0);
    v(65, 3'b010, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    v(66, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010);
    v(70, 0, 3'b010, 0, 0, 0, 0, 0, 0, 3'b010);
    v(71, 0, 0, 0, 3'b010, 0, 16'd5, 0, 0, 3'b010);
    for (int c = 75; c <= 78; c++) v(c, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3'b010);
    v(79, 3'b010, 3'b010, 0, 0, 0, 0, 0, 0, 3'b010);
    v(80, 0, 0, 0, 3'b010, 0, 16'd4, 0, 0, 3'b010);
    v(81, 0, 3'b010, 0, 0, 0, 0, 0, 0, 3'b010);
    for (int c = 82; c <= 84; c++) v(c, 0, 3'b010, 0, 3'b010, 0, 16'd5, 0, 0, 3'b010);
    v(85, 0, 0, 0, 3'b010, 0, 16'd5, 0, 0, 3'b010);
    s(90, 2'd1, 32'd7, 16'd4, 16'd9, 32'd38, 0, 0, 3'b010);
    s(91, 2'd0, 32'd3, 16'd3, 16'd5, 32'd13, 0, 0, 3'b010);
    s(92, 2'd3, 32'd0, 16'd0, 16'd0, 32'd0, 0, 0, 3'b010);
    v(99, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010);
    v(100, 0, 0, 0, 0, 0, 0, 3'b100, 0, 3'b010);
    v(102, 3'b001, 0, 0, 0, 0, 0, 3'b100, 0, 3'b010);
    v(104, 0, 3'b001, 0, 0, 0, 0, 3'b100, 0, 3'b010);
    v(105, 0, 0, 1, 3'b001, 16'd2, 0, 3'b100, 0, 3'b010);
    s(106, 2'd0, 32'd0, 16'hffff, 16'd0, 32'd0, 3'b100, 0, 0);
    // 8-bit stamp: 250 -> 260 wraps to stamp 4
    w(250, 1, 0, 0, 8'd0);
    w(260, 0, 1, 0, 8'd0);
    w(261, 0, 0, 1, 8'd10);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_lat_v", {lat_v_o, lat_v8}, '0);
    chk("reset_lat", lat_o, '0);
    chk("reset_flags", {timeout_o, overflow_o, underflow_o}, '0);
    chk_stat("reset_stat", 32'd0, 16'hffff, 16'd0, 32'd0);
    reset_n = 1'b1;
    cyc = 0;

    for (int k = 0; k < vecs.size(); k++) begin
      r = vecs[k];
      while (cyc < r.cyc) begin
        req = '0; cpl = '0; clr = 1'b0; req8 = '0; cpl8 = '0;
        #1;
        chk("idle_lat_v", {lat_v_o, lat_v8}, '0);
        step();
      end
      req = r.req; cpl = r.cpl; clr = r.clr; stat_sel = r.sel;
      req8 = {1'b0, r.req8}; cpl8 = {1'b0, r.cpl8};
      #1;
      chk("lat_v", lat_v_o, r.exp_v);
      if (r.exp_v[0]) chk("lat0", lat_o[15:0], r.lat0);
      if (r.exp_v[1]) chk("lat1", lat_o[31:16], r.lat1);
      chk("timeout", timeout_o, r.tmo);
      chk("overflow", overflow_o, r.ovf);
      chk("underflow", underflow_o, r.unf);
      chk("lat_v8", lat_v8, {1'b0, r.exp_v8});
      if (r.exp_v8) chk("lat8", lat8[7:0], r.lat8);
      if (r.chk_stat) chk_stat("stat", r.s_cnt, r.s_min, r.s_max, r.s_sum);
      step();
    end

    // mid-flight reset: LCE0 two entries, LCE1 one, LCE2 one outstanding
    req = 3'b011; cpl = '0; clr = 1'b0; req8 = '0; cpl8 = '0;
    step();
    req = 3'b011; cpl = 3'b010;
    step();
    req = '0; cpl = '0;
    #1;
    chk("pre_rst_lat_v", lat_v_o, 3'b010);
    chk("pre_rst_lat1", lat_o[31:16], 16'd1);
    step();
    stat_sel = 2'd1;
    #1;
    chk("pre_rst_count", stat_o[95:64], 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_lat_v", lat_v_o, '0);
    chk("rst_lat", lat_o, '0);
    chk("rst_flags", {timeout_o, overflow_o, underflow_o}, '0);
    chk_stat("rst_stat", 32'd0, 16'hffff, 16'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cpl = 3'b111;
    step();
    cpl = '0;
    #1;
    chk("post_rst_lat_v", lat_v_o, '0);
    chk("post_rst_underflow", underflow_o, 3'b111);
    chk("post_rst_timeout", timeout_o, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_idle", lat_v_o, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
